mat_vec_sequencer: RTL and testbench

MAT_VEC_SEQUENCER -- requirements
Module: mat_vec_sequencer

---
 rtl/mat_vec_sequencer.sv | 179 +++++++++++++++++
 tb/tb_mat_vec_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_vec_sequencer.sv
// Sequences a 4x4 matrix times 4-vector transform through an external
// dot-product stage: one matrix row per cycle out, one scalar result per cycle back.
module mat_vec_sequencer #(
  parameter int WIDTH       = 32,
  parameter int FIXED_POINT = 0,
  parameter int DP_LATENCY  = 3
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    mat_we,
  input  logic [3:0]              mat_addr,
  input  logic signed [WIDTH-1:0] mat_data,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic signed [WIDTH-1:0] vec_x,
  input  logic signed [WIDTH-1:0] vec_y,
  input  logic signed [WIDTH-1:0] vec_z,
  input  logic signed [WIDTH-1:0] vec_w,
  output logic signed [WIDTH-1:0] dp_x0,
  output logic signed [WIDTH-1:0] dp_x1,
  output logic signed [WIDTH-1:0] dp_x2,
  output logic signed [WIDTH-1:0] dp_x3,
  output logic signed [WIDTH-1:0] dp_y0,
  output logic signed [WIDTH-1:0] dp_y1,
  output logic signed [WIDTH-1:0] dp_y2,
  output logic signed [WIDTH-1:0] dp_y3,
  input  logic signed [WIDTH-1:0] dp_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic signed [WIDTH-1:0] res_x,
  output logic signed [WIDTH-1:0] res_y,
  output logic signed [WIDTH-1:0] res_z,
  output logic signed [WIDTH-1:0] res_w
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [WIDTH-1:0] UNIT = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DIAG = (FIXED_POINT != 0) ? (UNIT << (WIDTH/2)) : UNIT;

  logic [1:0]              state;
  logic [1:0]              issue_cnt;
  logic [1:0]              cap_cnt;
  logic [DP_LATENCY-1:0]   inflight;
  logic signed [WIDTH-1:0] mat [16];
  logic signed [WIDTH-1:0] vec_lat [4];
  logic                    accept;
  logic                    mat_wr;
  logic                    issue;
  logic                    capture;

  assign ready_out = (state == IDLE);
  assign accept    = valid_in && ready_out;
  assign mat_wr    = mat_we && ready_out;
  assign issue     = (state == ISSUE);
  // Tap of the in-flight pipe: set exactly DP_LATENCY edges after a row was issued.
  assign capture   = inflight[DP_LATENCY-1];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 16; i++) begin
        mat[i] <= ((i % 5) == 0) ? DIAG : '0;
      end
    end else if (mat_wr) begin
      mat[mat_addr] <= mat_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 4; i++) begin
        vec_lat[i] <= '0;
      end
    end else if (accept) begin
      vec_lat[0] <= vec_x;
      vec_lat[1] <= vec_y;
      vec_lat[2] <= vec_z;
      vec_lat[3] <= vec_w;
    end
  end

  // Matrix writes land at the accept edge, so row reads here already see them.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dp_x0 <= '0;
      dp_x1 <= '0;
      dp_x2 <= '0;
      dp_x3 <= '0;
      dp_y0 <= '0;
      dp_y1 <= '0;
      dp_y2 <= '0;
      dp_y3 <= '0;
    end else if (issue) begin
      dp_x0 <= mat[{issue_cnt, 2'd0}];
      dp_x1 <= mat[{issue_cnt, 2'd1}];
      dp_x2 <= mat[{issue_cnt, 2'd2}];
      dp_x3 <= mat[{issue_cnt, 2'd3}];
      dp_y0 <= vec_lat[0];
      dp_y1 <= vec_lat[1];
      dp_y2 <= vec_lat[2];
      dp_y3 <= vec_lat[3];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      inflight <= '0;
    end else begin
      inflight[0] <= issue;
      for (int i = 1; i < DP_LATENCY; i++) begin
        inflight[i] <= inflight[i-1];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cap_cnt <= 2'd0;
      res_x   <= '0;
      res_y   <= '0;
      res_z   <= '0;
      res_w   <= '0;
    end else if (capture) begin
      cap_cnt <= cap_cnt + 2'd1;
      case (cap_cnt)
        2'd0:    res_x <= dp_out;
        2'd1:    res_y <= dp_out;
        2'd2:    res_z <= dp_out;
        2'd3:    res_w <= dp_out;
        default: ;
      endcase
    end else if (accept) begin
      cap_cnt <= 2'd0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      issue_cnt <= 2'd0;
      valid_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= ISSUE;
            issue_cnt <= 2'd0;
          end
        end
        ISSUE: begin
          issue_cnt <= issue_cnt + 2'd1;
          if (issue_cnt == 2'd3) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (capture && (cap_cnt == 2'd3)) begin
            state     <= HOLD;
            valid_out <= 1'b1;
          end
        end
        HOLD: begin
          if (ready_in) begin
            state     <= IDLE;
            valid_out <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mat_vec_sequencer.sv
// Self-checking bench for mat_vec_sequencer: a behavioural dot-product stage,
// a matrix model, and a scoreboard of expected transformed vectors.
module tb_mat_vec_sequencer;

  localparam int W   = 32;
  localparam int DPL = 3;

  logic                clk_in = 1'b0;
  logic                rst_in = 1'b0;
  logic                mat_we = 1'b0;
  logic [3:0]          mat_addr = 4'd0;
  logic signed [W-1:0] mat_data = '0;
  logic                valid_in = 1'b0;
  logic                ready_out;
  logic signed [W-1:0] vec_x = '0, vec_y = '0, vec_z = '0, vec_w = '0;
  logic signed [W-1:0] dp_x0, dp_x1, dp_x2, dp_x3;
  logic signed [W-1:0] dp_y0, dp_y1, dp_y2, dp_y3;
  logic signed [W-1:0] dp_out;
  logic                valid_out;
  logic                ready_in = 1'b0;
  logic signed [W-1:0] res_x, res_y, res_z, res_w;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic signed [W-1:0] m_model [16];
  logic [4*W-1:0]      sb [$];
  logic signed [W-1:0] dp_pipe [DPL-1];

  mat_vec_sequencer #(.WIDTH(W), .FIXED_POINT(0), .DP_LATENCY(DPL)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .mat_we(mat_we), .mat_addr(mat_addr), .mat_data(mat_data),
    .valid_in(valid_in), .ready_out(ready_out),
    .vec_x(vec_x), .vec_y(vec_y), .vec_z(vec_z), .vec_w(vec_w),
    .dp_x0(dp_x0), .dp_x1(dp_x1), .dp_x2(dp_x2), .dp_x3(dp_x3),
    .dp_y0(dp_y0), .dp_y1(dp_y1), .dp_y2(dp_y2), .dp_y3(dp_y3),
    .dp_out(dp_out), .valid_out(valid_out), .ready_in(ready_in),
    .res_x(res_x), .res_y(res_y), .res_z(res_z), .res_w(res_w)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic signed [W-1:0] dot4(
    input logic signed [W-1:0] a0, a1, a2, a3, b0, b1, b2, b3);
    return a0 * b0 + a1 * b1 + a2 * b2 + a3 * b3;
  endfunction

  // Downstream stage: result for operands launched at edge t is present for sampling at edge t+DPL.
  always @(posedge clk_in) begin
    dp_pipe[0] <= dot4(dp_x0, dp_x1, dp_x2, dp_x3, dp_y0, dp_y1, dp_y2, dp_y3);
    for (int i = 1; i < DPL - 1; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign dp_out = dp_pipe[DPL-2];

  function automatic logic [4*W-1:0] expect_mv(input logic signed [W-1:0] x, y, z, w);
    logic signed [W-1:0] r [4];
    for (int i = 0; i < 4; i++)
      r[i] = m_model[4*i] * x + m_model[4*i+1] * y + m_model[4*i+2] * z + m_model[4*i+3] * w;
    return {r[3], r[2], r[1], r[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_model[i] = ((i % 5) == 0) ? 32'sd1 : 32'sd0;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_vec(input logic signed [W-1:0] x, y, z, w, input bit wr,
                          input logic [3:0] a, input logic signed [W-1:0] d,
                          input bit push, output int acc_cyc);
    int guard;
    guard = 0;
    while (!ready_out && guard < 50) begin
      step();
      guard++;
    end
    checks++;
    if (!ready_out) begin
      $display("FAIL send_ready_timeout ready_out=%0b required=1", ready_out);
      errors++;
    end
    vec_x = x; vec_y = y; vec_z = z; vec_w = w;
    valid_in = 1'b1;
    if (wr) begin
      mat_we = 1'b1; mat_addr = a; mat_data = d;
      m_model[a] = d;
    end
    if (push) sb.push_back(expect_mv(x, y, z, w));
    step();
    acc_cyc = cyc;
    valid_in = 1'b0;
    mat_we = 1'b0;
  endtask

  task automatic wait_result(input int hold, input bit early_ready, input string name);
    int lat;
    logic [4*W-1:0] snap, exp_v;
    ready_in = early_ready;
    lat = 0;
    while (!valid_out && lat < 40) begin
      step();
      lat++;
    end
    checks++;
    if (!valid_out) begin
      $display("FAIL %s_timeout valid_out=0 required=1 after %0d cycles", name, lat);
      errors++;
      ready_in = 1'b0;
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    checks++;
    if (lat !== DPL + 4) begin
      $display("FAIL %s_latency got %0d required %0d", name, lat, DPL + 4);
      errors++;
    end
    snap = {res_w, res_z, res_y, res_x};
    for (int i = 0; i < hold; i++) begin
      valid_in = 1'b1; mat_we = 1'b1; mat_addr = 4'd0; mat_data = 32'sd99;
      vec_x = 32'sd9; vec_y = 32'sd9; vec_z = 32'sd9; vec_w = 32'sd9;
      step();
      checks++;
      if (valid_out !== 1'b1 || ready_out !== 1'b0 || {res_w, res_z, res_y, res_x} !== snap) begin
        $display("FAIL %s_hold cycle %0d valid_out=%0b ready_out=%0b res=%h required 1/0/%h",
                 name, i, valid_out, ready_out, {res_w, res_z, res_y, res_x}, snap);
        errors++;
      end
    end
    valid_in = 1'b0;
    mat_we = 1'b0;
    checks++;
    if (sb.size() == 0) begin
      $display("FAIL %s_scoreboard_empty res=%h", name, snap);
      errors++;
    end else begin
      exp_v = sb.pop_front();
      if (snap !== exp_v) begin
        $display("FAIL %s_result got %h required %h", name, snap, exp_v);
        errors++;
      end
    end
    ready_in = 1'b1;
    step();
    ready_in = 1'b0;
    checks++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      $display("FAIL %s_handshake valid_out=%0b ready_out=%0b required 0/1", name, valid_out, ready_out);
      errors++;
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    valid_in = 1'b1; mat_we = 1'b1; mat_addr = 4'd0; mat_data = 32'sd55;
    vec_x = 32'sd3; vec_y = 32'sd3; vec_z = 32'sd3; vec_w = 32'sd3;
    repeat (3) step();
    rst_in = 1'b0; valid_in = 1'b0; mat_we = 1'b0;
    model_reset();
    checks++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
      $display("FAIL reset_flags ready_out=%0b valid_out=%0b required 1/0", ready_out, valid_out);
      errors++;
    end
    checks++;
    if ({res_w, res_z, res_y, res_x} !== '0) begin
      $display("FAIL reset_res got %h required 0", {res_w, res_z, res_y, res_x});
      errors++;
    end
    checks++;
    if ({dp_x0, dp_x1, dp_x2, dp_x3, dp_y0, dp_y1, dp_y2, dp_y3} !== '0) begin
      $display("FAIL reset_dp got %h required 0", {dp_x0, dp_x1, dp_x2, dp_x3, dp_y0, dp_y1, dp_y2, dp_y3});
      errors++;
    end
    step();
    checks++;
    if (ready_out !== 1'b1) begin
      $display("FAIL reset_no_accept ready_out=%0b required 1", ready_out);
      errors++;
    end
  endtask

  task automatic test_identity_hold();
    int t;
    send_vec(32'sd1, 32'sd2, 32'sd3, 32'sd4, 1'b0, 4'd0, '0, 1'b1, t);
    wait_result(5, 1'b0, "identity_hold");
  endtask

  task automatic test_matrix();
    int t;
    logic signed [W-1:0] vals [16] = '{32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd0, 32'sd1, 32'sd0, 32'sd0,
                                      32'sd0, 32'sd0, 32'sd2, 32'sd0, 32'sd5, 32'sd0, 32'sd0, 32'sd1};
    for (int i = 0; i < 16; i++) begin
      mat_we = 1'b1; mat_addr = 4'(i); mat_data = vals[i];
      m_model[i] = vals[i];
      step();
    end
    mat_we = 1'b0;
    send_vec(32'sd1, 32'sd1, 32'sd1, 32'sd1, 1'b0, 4'd0, '0, 1'b1, t);
    checks++;
    if (sb[sb.size()-1] !== {32'sd6, 32'sd2, 32'sd1, 32'sd10}) begin
      $display("FAIL matrix_model got %h required (10,1,2,6)", sb[sb.size()-1]);
      errors++;
    end
    wait_result(0, 1'b0, "matrix");
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    send_vec(-32'sd3, 32'sd5, 32'sd7, -32'sd2, 1'b0, 4'd0, '0, 1'b1, t1);
    wait_result(0, 1'b1, "b2b_a");
    send_vec(32'sd100, -32'sd1, 32'sd0, 32'sd8, 1'b0, 4'd0, '0, 1'b1, t2);
    checks++;
    if (t2 - t1 !== DPL + 6) begin
      $display("FAIL b2b_spacing got %0d required %0d", t2 - t1, DPL + 6);
      errors++;
    end
    wait_result(0, 1'b1, "b2b_b");
  endtask

  task automatic test_mid_reset();
    int t;
    bit seen;
    send_vec(32'sd11, 32'sd12, 32'sd13, 32'sd14, 1'b0, 4'd0, '0, 1'b0, t);
    step();
    step();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    model_reset();
    checks++;
    if (ready_out !== 1'b1 || dp_x0 !== '0 || res_x !== '0) begin
      $display("FAIL midrst_state ready_out=%0b dp_x0=%h res_x=%h required 1/0/0", ready_out, dp_x0, res_x);
      errors++;
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (valid_out !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      $display("FAIL midrst_valid valid_out rose=1 required 0");
      errors++;
    end
    send_vec(32'sd1, 32'sd2, 32'sd3, 32'sd4, 1'b0, 4'd0, '0, 1'b1, t);
    wait_result(0, 1'b0, "midrst_fresh");
  endtask

  task automatic test_same_edge();
    int t;
    send_vec(32'sd1, 32'sd0, 32'sd0, 32'sd0, 1'b1, 4'd0, 32'sd7, 1'b1, t);
    checks++;
    if (sb[sb.size()-1] !== {32'sd0, 32'sd0, 32'sd0, 32'sd7}) begin
      $display("FAIL same_edge_model got %h required (7,0,0,0)", sb[sb.size()-1]);
      errors++;
    end
    wait_result(0, 1'b0, "same_edge");
  endtask

  initial begin
    test_reset();
    test_identity_hold();
    test_matrix();
    test_back_to_back();
    test_mid_reset();
    test_same_edge();
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_leftover got %0d required 0", sb.size());
      errors++;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
